// File: rtl/hdb3_pkg.sv
// Shared symbol codes, scheduler states and small helpers for the HDB3 transmit scheduler.
package hdb3_pkg;

    typedef enum logic [1:0] {
        SYM_ZERO = 2'b00,
        SYM_ONE  = 2'b01,
        SYM_V    = 2'b10,
        SYM_B    = 2'b11
    } sym_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_RUN   = 2'b10,
        ST_FLUSH = 2'b11
    } state_e;

    localparam logic [2:0] WIN_FULL = 3'd4;
    localparam logic [1:0] LOCK_SUB = 2'd3;

    // Symbols that take the alternating polarity and count toward parity.
    function automatic logic is_pulse(input sym_e sym);
        return (sym == SYM_ONE) || (sym == SYM_B);
    endfunction

endpackage

// File: rtl/hdb3_lookahead_buf.sv
// Four-entry FIFO-order look-ahead window; index 0 is the oldest bit.
module hdb3_lookahead_buf
    import hdb3_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic       i_bit,
    output logic [2:0] o_cnt,
    output logic       o_head,
    output logic       o_all_zero
);

    logic [3:0] r_win;
    logic [2:0] r_cnt;
    logic [3:0] w_win_nxt;
    logic [2:0] w_cnt_base;
    logic [2:0] w_cnt_nxt;

    // Shift out the head on pop, then write the new bit just past the survivors.
    always_comb begin
        w_win_nxt  = r_win;
        w_cnt_base = r_cnt;
        if (i_pop) begin
            w_win_nxt  = {1'b0, r_win[3:1]};
            w_cnt_base = r_cnt - 3'd1;
        end else begin
            w_win_nxt  = r_win;
            w_cnt_base = r_cnt;
        end
        if (i_push) begin
            w_win_nxt[w_cnt_base[1:0]] = i_bit;
            w_cnt_nxt                  = w_cnt_base + 3'd1;
        end else begin
            w_cnt_nxt = w_cnt_base;
        end
    end

    // Window contents and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win <= 4'b0000;
            r_cnt <= 3'd0;
        end else begin
            r_win <= w_win_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_cnt      = r_cnt;
    assign o_head     = r_win[0];
    assign o_all_zero = (r_cnt == WIN_FULL) && (r_win == 4'b0000);

endmodule

// File: rtl/hdb3_enc_scheduler.sv
// HDB3 transmit scheduler: handshaked look-ahead window, B/V substitution and AMI polarity.
module hdb3_enc_scheduler #(
    parameter logic INIT_LAST_POL = 1'b1,
    parameter logic INIT_PARITY   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       flush,
    output logic [1:0] out_sym,
    output logic       out_pol,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);
    import hdb3_pkg::*;

    state_e     r_state;
    state_e     w_state_nxt;
    logic [1:0] r_lock;
    logic       r_parity;
    // Set when the last pulse sent was negative, so ones/B go out with this value as polarity.
    logic       r_last_neg;

    logic [2:0] w_cnt;
    logic [2:0] w_cnt_nxt;
    logic       w_head;
    logic       w_all_zero;
    logic       w_push;
    logic       w_pop;
    logic       w_flush;
    logic       w_sym_avail;
    sym_e       w_sym;
    logic       w_pol;

    hdb3_lookahead_buf u_buf (
        .clk        (clk),
        .rst_n      (rst),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_bit      (in_bit),
        .o_cnt      (w_cnt),
        .o_head     (w_head),
        .o_all_zero (w_all_zero)
    );

    assign w_sym_avail = (w_cnt == WIN_FULL) || ((r_state == ST_FLUSH) && (w_cnt != 3'd0));
    assign out_valid   = en && w_sym_avail;
    assign w_pop       = out_valid && out_ready;
    assign in_ready    = en && (r_state != ST_FLUSH) && ((w_cnt < WIN_FULL) || w_pop);
    assign w_push      = in_valid && in_ready;
    assign w_flush     = en && flush;
    assign w_cnt_nxt   = w_cnt + {2'b00, w_push} - {2'b00, w_pop};
    assign busy        = (r_state != ST_IDLE);
    assign out_sym     = w_sym;
    assign out_pol     = w_pol;

    // Symbol decode purely from registered window, lock, parity and polarity.
    always_comb begin
        w_sym = SYM_ZERO;
        w_pol = 1'b0;
        if (!w_sym_avail) begin
            w_sym = SYM_ZERO;
        end else if (r_lock == 2'd1) begin
            w_sym = SYM_V;
            w_pol = ~r_last_neg;
        end else if (r_lock != 2'd0) begin
            w_sym = SYM_ZERO;
        end else if (w_all_zero) begin
            if (r_parity) begin
                w_sym = SYM_ZERO;
            end else begin
                w_sym = SYM_B;
                w_pol = r_last_neg;
            end
        end else if (w_head) begin
            w_sym = SYM_ONE;
            w_pol = r_last_neg;
        end else begin
            w_sym = SYM_ZERO;
        end
    end

    // Next-state logic; a flush that coincides with an accept still keeps that bit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_push) begin
                    w_state_nxt = w_flush ? ST_FLUSH : ST_FILL;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (w_flush) begin
                    w_state_nxt = ST_FLUSH;
                end else if (w_cnt_nxt == WIN_FULL) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_RUN: begin
                if (w_flush) begin
                    w_state_nxt = ST_FLUSH;
                end else if (w_cnt_nxt != WIN_FULL) begin
                    w_state_nxt = ST_FILL;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (w_cnt_nxt == 3'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Substitution lock, parity and polarity advance only when a symbol actually pops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lock     <= 2'd0;
            r_parity   <= INIT_PARITY;
            r_last_neg <= INIT_LAST_POL;
        end else if (w_pop) begin
            if ((r_lock == 2'd0) && w_all_zero) begin
                r_lock <= LOCK_SUB;
            end else if (r_lock != 2'd0) begin
                r_lock <= r_lock - 2'd1;
            end
            if (w_sym == SYM_V) begin
                r_parity <= 1'b0;
            end else if (is_pulse(w_sym)) begin
                r_parity   <= ~r_parity;
                r_last_neg <= ~r_last_neg;
            end
        end
    end

endmodule

// File: doc/hdb3_enc_scheduler.md
# hdb3_enc_scheduler

Sequencing controller for the HDB3 transmit path. It accepts a serial NRZ bit stream over a valid/ready handshake and holds a 4-bit look-ahead window. It decides for each symbol whether to emit a mark, a zero, a B pulse or a V pulse, and assigns every pulse its line polarity. It sits between the bit source and the line driver and replaces the free-running V-marking stage with a handshaked, back-pressurable scheduler.

## Interface
- `INIT_LAST_POL`, default 1'b1: polarity treated as "last pulse sent" after reset (1 = negative), so the first pulse is positive.
- `INIT_PARITY`, default 1'b0: parity of the pulse count since the last V after reset (0 = even).
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock, asynchronous, active-low.
- `en`  in  1  global enable; when low, all state freezes and `in_ready` = `out_valid` = 0.
- `in_bit`  in  1  NRZ data bit.
- `in_valid`  in  1  `in_bit` is valid.
- `in_ready`  out  1  a bit is accepted on `in_valid && in_ready`.
- `flush`  in  1  single-cycle pulse: no further input, drain the window.
- `out_sym`  out  2  symbol code (zero, one, V, B).
- `out_pol`  out  1  pulse polarity (1 = positive, 0 = negative); 0 for a zero symbol.
- `out_valid`  out  1  `out_sym`/`out_pol` are valid.
- `out_ready`  in  1  a symbol pops on `out_valid && out_ready`.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **Storage:** 4-entry FIFO-order window, `cnt` 0..4; head is the oldest bit.
- **States:**
  - IDLE: `cnt` = 0.
  - FILL: 1..3 entries, no output.
  - RUN: 4 entries.
  - FLUSH: draining, `in_ready` = 0.
- **Transitions:**
  - IDLE→FILL on accept.
  - FILL→RUN when `cnt` reaches 4.
  - RUN stays in RUN while an accept and a pop occur together.
  - FILL or RUN→FLUSH on `flush`. A `flush` coincident with an accept takes that bit first.
  - FLUSH→IDLE when the last entry pops.
  - RUN with a pop and no accept drops to FILL.
- **Output handshake:**
  - `out_valid` = `en` && (`cnt` == 4 || (FLUSH && `cnt` > 0)).
  - `in_ready` = `en` && !FLUSH && (`cnt` < 4 || pop this cycle). A same-cycle pop and accept keeps `cnt` unchanged.
- **Substitution:**
  - Condition: `lock` == 0, `cnt` == 4 and all four entries are 0.
  - Parity odd → head emits zero (000V). Parity even → head emits B (B00V).
  - On that pop `lock` is set to 3. Pops with `lock` = 3 or 2 emit zero. The pop with `lock` = 1 emits V. `lock` decrements on each pop.
  - Fewer than 4 trailing zeros during FLUSH emit plain zeros.
- **Polarity:**
  - One and B: `out_pol` = ~`last_pol`; on pop, `last_pol` is updated to that value.
  - V: `out_pol` = `last_pol`; `last_pol` is unchanged.
- **Parity:** toggles on each popped one or B; cleared to 0 on a popped V.
- **State across frames:** `last_pol` and parity are kept across FLUSH→IDLE (continuous line).
- **No input path to outputs:** `out_*` decode only from registered state, with no combinational path from `in_*`. `in_ready` depends combinationally on `out_ready`.

## Timing
- **Reset values:**
  - `cnt` = 0, `lock` = 0, state IDLE, `last_pol` = `INIT_LAST_POL`, parity = `INIT_PARITY`.
  - `out_valid` = 0, `out_sym` = 2'b00, `out_pol` = 0, `busy` = 0, `in_ready` = `en`.
- **Latency:** the first symbol is valid the cycle after the 4th accept. Steady state is one symbol per cycle with `out_ready` = 1.
- **Backpressure:** with `out_ready` low at `cnt` = 4, `in_ready` = 0. No bit is lost or duplicated.
- **Reset mid-stream:** the window contents are discarded immediately and all registers return to their reset values.
- **`en` low:** takes effect the same cycle; the handshake stalls cleanly.

## Structure
- **Package `hdb3_pkg`:**
  - Symbol codes: `SYM_ZERO` = 2'b00, `SYM_ONE` = 2'b01, `SYM_V` = 2'b10, `SYM_B` = 2'b11.
  - State encoding: IDLE, FILL, RUN, FLUSH.
- **Sub-module `hdb3_lookahead_buf`:** 4-entry shift window with push, pop, `cnt` and an all-zero flag.
- **Top level:** FSM, `lock`, parity and polarity logic stay in the top level.

## Test plan
1. After reset, bits 1,0,0,0,0 then `flush` → ONE+, ZERO, ZERO, ZERO, V+ (odd parity gives 000V).
2. After reset, 8 zeros then `flush` → B+, 0, 0, V+, B−, 0, 0, V−.
3. After reset, 1,1,0,0,0,0 then `flush` → ONE+, ONE−, B+, 0, 0, V+.
4. 4 bits buffered, `out_ready` = 0 for 5 cycles while `in_valid` is held → `in_ready` = 0 throughout. After release, the output sequence is gapless and complete.
5. Bits 1,0,0,0 then `flush` → ONE+, ZERO, ZERO, ZERO, no V. `busy` falls the cycle after the last pop.
6. `rst` low after 6 accepts → `out_valid` = 0 and `busy` = 0 immediately. Replaying case 1 then reproduces case 1 exactly.
